// File: rtl/rgb_hsmooth_if.sv
// Avalon-ST style video stream bundle: 24-bit {R,G,B} data with sop/eop framing
// and valid/ready handshake (ready latency 0).
//   master: drives data/valid/sop/eop, receives ready (the producer side)
//   slave : receives data/valid/sop/eop, drives ready (the consumer side)
interface rgb_hsmooth_if;
  logic [23:0] data;
  logic        valid;
  logic        ready;
  logic        sop;
  logic        eop;

  modport master (output data, output valid, output sop, output eop, input ready);
  modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/rgb_hsmooth.sv
// Streaming horizontal [1 2 1]/4 smoothing filter for 24-bit RGB video.
// Video packets (header low nibble 0, enable=1) are filtered per channel with
// edge replication at both ends of each row; every other packet passes untouched.
// Each filtered row costs exactly one extra cycle, which is used to emit the
// right-edge pixel.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   sink        input stream (slave modport; sink.ready is driven here)
//   source      output stream (master modport)
//   enable      0 = pass video unfiltered; sampled only on an accepted sop word
//   frame_count video frames completed (only with HSMOOTH_FRAME_STATS_EN)
//   width_err   sticky row-width / row-count error (only with HSMOOTH_FRAME_STATS_EN)
//
// Optional feature: define HSMOOTH_FRAME_STATS_EN to add frame_count and width_err.
module rgb_hsmooth #(
  parameter int unsigned IMAGE_W = 640,
  parameter int unsigned IMAGE_H = 480
) (
  input  logic          clk,
  input  logic          reset,
  rgb_hsmooth_if.slave  sink,
  rgb_hsmooth_if.master source,
  input  logic          enable
`ifdef HSMOOTH_FRAME_STATS_EN
  ,
  output logic [15:0]   frame_count,
  output logic [0:0]    width_err
`endif
);

  localparam int unsigned ColW = (IMAGE_W > 2) ? $clog2(IMAGE_W) : 1;
  localparam logic [ColW-1:0] LastCol = ColW'(IMAGE_W - 1);

  // The column logic needs at least two pixels per row.
  if (IMAGE_W < 2 || IMAGE_H < 1) begin : g_param_check
    $error("rgb_hsmooth: IMAGE_W must be >= 2 and IMAGE_H >= 1");
  end

  typedef enum logic [1:0] {StIdle, StPass, StVideo, StFlush} state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] column_q, column_d;
  logic [23:0]     p0_q, p0_d, p1_q, p1_d;
  logic            pending_q, pending_d;
  logic            eop_lat_q, eop_lat_d;
  logic [23:0]     out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_sop_q, out_sop_d;
  logic            out_eop_q, out_eop_d;

  logic out_free;
  logic sink_ready;
  logic accept;

  // Per channel: (a + 2b + c + 2) >> 2 with a 10-bit sum; cannot exceed 255.
  function automatic logic [23:0] filt(input logic [23:0] a, input logic [23:0] b,
                                       input logic [23:0] c);
    logic [9:0]  sum;
    logic [23:0] res;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      sum = {2'b00, a[8*i +: 8]} + {1'b0, b[8*i +: 8], 1'b0} + {2'b00, c[8*i +: 8]} + 10'd2;
      res[8*i +: 8] = sum[9:2];
    end
    return res;
  endfunction

  assign out_free   = ~out_valid_q | source.ready;
  assign sink_ready = (state_q != StFlush) & out_free;
  assign accept     = sink.valid & sink_ready;

  assign sink.ready    = sink_ready;
  assign source.data   = out_data_q;
  assign source.valid  = out_valid_q;
  assign source.sop    = out_sop_q;
  assign source.eop    = out_eop_q;

  always_comb begin
    state_d     = state_q;
    column_d    = column_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    pending_d   = pending_q;
    eop_lat_d   = eop_lat_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~source.ready;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;

    unique case (state_q)
      StFlush: begin
        if (out_free) begin
          out_data_d  = filt(p0_q, p1_q, p1_q);
          out_valid_d = 1'b1;
          out_sop_d   = 1'b0;
          out_eop_d   = eop_lat_q;
          pending_d   = 1'b0;
          column_d    = '0;
          state_d     = eop_lat_q ? StIdle : StVideo;
        end
      end
      StIdle, StPass, StVideo: begin
        if (accept) begin
          if (sink.sop) begin
            // New packet header from any state; held video pixels are discarded.
            out_data_d  = sink.data;
            out_valid_d = 1'b1;
            out_sop_d   = 1'b1;
            out_eop_d   = sink.eop;
            pending_d   = 1'b0;
            column_d    = '0;
            if (sink.eop) begin
              state_d = StIdle;
            end else if (sink.data[3:0] == 4'd0 && enable) begin
              state_d = StVideo;
            end else begin
              state_d = StPass;
            end
          end else if (state_q == StPass) begin
            out_data_d  = sink.data;
            out_valid_d = 1'b1;
            out_sop_d   = 1'b0;
            out_eop_d   = sink.eop;
            if (sink.eop) begin
              state_d = StIdle;
            end
          end else if (state_q == StVideo) begin
            if (!pending_q) begin
              // First pixel of a row: replicate left edge, nothing to emit yet.
              p0_d      = sink.data;
              p1_d      = sink.data;
              pending_d = 1'b1;
            end else begin
              out_data_d  = filt(p0_q, p1_q, sink.data);
              out_valid_d = 1'b1;
              out_sop_d   = 1'b0;
              out_eop_d   = 1'b0;
              p0_d        = p1_q;
              p1_d        = sink.data;
            end
            if (column_q == LastCol || sink.eop) begin
              state_d   = StFlush;
              eop_lat_d = sink.eop;
            end else begin
              column_d = column_q + ColW'(1);
            end
          end
          // Non-sop words in StIdle are dropped.
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      column_q    <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      pending_q   <= 1'b0;
      eop_lat_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      column_q    <= column_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      pending_q   <= pending_d;
      eop_lat_q   <= eop_lat_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

`ifdef HSMOOTH_FRAME_STATS_EN
  logic [15:0] frame_count_q;
  logic [15:0] row_q;
  logic        width_err_q;
  logic        flush_fire;
  logic        video_eop;
  logic        video_start;

  assign flush_fire  = (state_q == StFlush) & out_free;
  assign video_eop   = (state_q == StVideo) & accept & ~sink.sop & sink.eop;
  assign video_start = accept & sink.sop & ~sink.eop & (sink.data[3:0] == 4'd0) & enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count_q <= '0;
      row_q         <= '0;
      width_err_q   <= 1'b0;
    end else begin
      if (video_start) begin
        row_q <= '0;
      end else if (flush_fire) begin
        if (eop_lat_q) begin
          frame_count_q <= frame_count_q + 16'd1;
          row_q         <= '0;
          if (row_q + 16'd1 != 16'(IMAGE_H)) begin
            width_err_q <= 1'b1;
          end
        end else begin
          row_q <= row_q + 16'd1;
        end
      end
      if (video_eop && column_q != LastCol) begin
        width_err_q <= 1'b1;
      end
    end
  end

  assign frame_count  = frame_count_q;
  assign width_err[0] = width_err_q;
`endif

endmodule

// File: tb/tb_rgb_hsmooth.sv
// Directed bench for rgb_hsmooth with IMAGE_W=4, IMAGE_H=2.
module tb_rgb_hsmooth;

  localparam int unsigned W = 4;
  localparam int unsigned H = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic toggle_ready = 1'b0;
  logic mon_en = 1'b0;

  rgb_hsmooth_if sink_if ();
  rgb_hsmooth_if source_if ();

`ifdef HSMOOTH_FRAME_STATS_EN
  logic [15:0] frame_count;
  logic [0:0]  width_err;
`endif

  rgb_hsmooth #(
    .IMAGE_W(W),
    .IMAGE_H(H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sink(sink_if),
    .source(source_if),
    .enable(enable)
`ifdef HSMOOTH_FRAME_STATS_EN
    ,
    .frame_count(frame_count),
    .width_err(width_err)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int stall_cnt = 0;
  int viol_cnt = 0;
  logic [25:0] got_q[$];
  logic [25:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] wd(input logic s, input logic e, input logic [23:0] d);
    return {s, e, d};
  endfunction

  // Downstream ready: constant 1, or toggling every cycle when requested.
  initial begin
    source_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      source_if.ready = toggle_ready ? ~source_if.ready : 1'b1;
    end
  end

  // Sampled on the falling edge; the handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (source_if.valid && source_if.ready)
        got_q.push_back({source_if.sop, source_if.eop, source_if.data});
      if (!sink_if.ready)
        stall_cnt++;
      if (source_if.valid && !source_if.ready && sink_if.ready)
        viol_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [23:0] d, input logic s, input logic e);
    int n;
    n = 0;
    sink_if.data  = d;
    sink_if.sop   = s;
    sink_if.eop   = e;
    sink_if.valid = 1'b1;
    forever begin
      @(negedge clk);
      if (sink_if.ready) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 32'(sink_if.ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    sink_if.valid = 1'b0;
    sink_if.sop   = 1'b0;
    sink_if.eop   = 1'b0;
  endtask

  task automatic start_test();
    got_q.delete();
    exp_q.delete();
    stall_cnt = 0;
  endtask

  task automatic finish_test(input string tag);
    repeat (12) @(posedge clk);
    #1;
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
  endtask

  // Header plus one row R = 10,20,30,40 with eop on the last pixel.
  task automatic send_basic();
    send(24'h000000, 1'b1, 1'b0);
    send(24'h0A0000, 1'b0, 1'b0);
    send(24'h140000, 1'b0, 1'b0);
    send(24'h1E0000, 1'b0, 1'b0);
    send(24'h280000, 1'b0, 1'b1);
  endtask

  // Hand-computed: 13=(10+20+20+2)/4, 20, 30, 38=(30+80+40+2)/4.
  task automatic exp_basic();
    exp_q.push_back(wd(1'b1, 1'b0, 24'h000000));
    exp_q.push_back(wd(1'b0, 1'b0, 24'h0D0000));
    exp_q.push_back(wd(1'b0, 1'b0, 24'h140000));
    exp_q.push_back(wd(1'b0, 1'b0, 24'h1E0000));
    exp_q.push_back(wd(1'b0, 1'b1, 24'h260000));
  endtask

  initial begin
    sink_if.data  = '0;
    sink_if.valid = 1'b0;
    sink_if.sop   = 1'b0;
    sink_if.eop   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(source_if.valid), 32'd0);
    check("rst_data", 32'(source_if.data), 32'd0);
    check("rst_sop", 32'(source_if.sop), 32'd0);
    check("rst_eop", 32'(source_if.eop), 32'd0);
    check("rst_sink_ready", 32'(sink_if.ready), 32'd1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // 1: filtered row
    enable = 1'b1;
    start_test();
    send_basic();
    exp_basic();
    finish_test("t1");
    check("t1_stall", 32'(stall_cnt), 32'd1);

    // 2: enable=0 passes the same packet verbatim, no flush stall
    enable = 1'b0;
    start_test();
    send_basic();
    exp_q.push_back(wd(1'b1, 1'b0, 24'h000000));
    exp_q.push_back(wd(1'b0, 1'b0, 24'h0A0000));
    exp_q.push_back(wd(1'b0, 1'b0, 24'h140000));
    exp_q.push_back(wd(1'b0, 1'b0, 24'h1E0000));
    exp_q.push_back(wd(1'b0, 1'b1, 24'h280000));
    finish_test("t2");
    check("t2_stall", 32'(stall_cnt), 32'd0);

    // 3: non-video packet passes unchanged
    enable = 1'b1;
    start_test();
    send(24'h00000F, 1'b1, 1'b0);
    send(24'hABCDEF, 1'b0, 1'b0);
    send(24'h123456, 1'b0, 1'b1);
    exp_q.push_back(wd(1'b1, 1'b0, 24'h00000F));
    exp_q.push_back(wd(1'b0, 1'b0, 24'hABCDEF));
    exp_q.push_back(wd(1'b0, 1'b1, 24'h123456));
    finish_test("t3");

    // 4: toggling downstream ready gives the same sequence as scenario 1
    toggle_ready = 1'b1;
    start_test();
    send_basic();
    exp_basic();
    finish_test("t4");
    toggle_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t4_ready_rule", 32'(viol_cnt), 32'd0);

    // 5: two rows, eop on the 8th pixel; row 2 exercises G and saturated B
    start_test();
    send(24'h000000, 1'b1, 1'b0);
    send(24'h0A0000, 1'b0, 1'b0);
    send(24'h140000, 1'b0, 1'b0);
    send(24'h1E0000, 1'b0, 1'b0);
    send(24'h280000, 1'b0, 1'b0);
    send(24'h0064FF, 1'b0, 1'b0);
    send(24'h0064FF, 1'b0, 1'b0);
    send(24'h0064FF, 1'b0, 1'b0);
    send(24'h00C8FF, 1'b0, 1'b1);
    exp_q.push_back(wd(1'b1, 1'b0, 24'h000000));
    exp_q.push_back(wd(1'b0, 1'b0, 24'h0D0000));
    exp_q.push_back(wd(1'b0, 1'b0, 24'h140000));
    exp_q.push_back(wd(1'b0, 1'b0, 24'h1E0000));
    exp_q.push_back(wd(1'b0, 1'b0, 24'h260000));
    exp_q.push_back(wd(1'b0, 1'b0, 24'h0064FF));
    exp_q.push_back(wd(1'b0, 1'b0, 24'h0064FF));
    exp_q.push_back(wd(1'b0, 1'b0, 24'h007DFF));  // (100+200+200+2)/4 = 125
    exp_q.push_back(wd(1'b0, 1'b1, 24'h00AFFF));  // (100+400+200+2)/4 = 175
    finish_test("t5");
    check("t5_stall", 32'(stall_cnt), 32'd2);

    // 6: reset after the second pixel of a row, then a clean packet
    start_test();
    send(24'h000000, 1'b1, 1'b0);
    send(24'h0A0000, 1'b0, 1'b0);
    send(24'h140000, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_valid_after_rst", 32'(source_if.valid), 32'd0);
`ifdef HSMOOTH_FRAME_STATS_EN
    check("t6_frame_count_rst", 32'(frame_count), 32'd0);
`endif
    @(posedge clk);
    #1;
    start_test();
    send_basic();
    exp_basic();
    finish_test("t6");

    // 7: sop mid-row discards held pixels and starts a fresh packet
    start_test();
    send(24'h000000, 1'b1, 1'b0);
    send(24'h0A0000, 1'b0, 1'b0);
    send(24'h140000, 1'b0, 1'b0);
    exp_q.push_back(wd(1'b1, 1'b0, 24'h000000));
    exp_q.push_back(wd(1'b0, 1'b0, 24'h0D0000));
    send_basic();
    exp_basic();
    finish_test("t7");

    // 8: eop mid-row flushes a short row; (10+40+20+2)/4 = 18
    start_test();
    send(24'h000000, 1'b1, 1'b0);
    send(24'h0A0000, 1'b0, 1'b0);
    send(24'h140000, 1'b0, 1'b1);
    exp_q.push_back(wd(1'b1, 1'b0, 24'h000000));
    exp_q.push_back(wd(1'b0, 1'b0, 24'h0D0000));
    exp_q.push_back(wd(1'b0, 1'b1, 24'h120000));
    finish_test("t8");
    check("t8_stall", 32'(stall_cnt), 32'd1);

`ifdef HSMOOTH_FRAME_STATS_EN
    // Frames since the reset in scenario 6: t6, t7, t8; single-row frames flag an error.
    check("stats_frame_count", 32'(frame_count), 32'd3);
    check("stats_width_err", 32'(width_err), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
